// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT output stage.
//   DW     width of each real/imag component (two's complement)
//   N      points per frame (power of two)
//   LOGN   log2(N), width of sample indices
//   cplx_t packed complex sample {re, im}
//   bitrev reverses the LOGN-bit index
package fft_pkg;

    localparam int DW   = 16;
    localparam int N    = 8;
    localparam int LOGN = 3;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] idx);
        logic [LOGN-1:0] r;
        r = '0;
        for (int i = 0; i < LOGN; i++) begin
            r[i] = idx[LOGN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One bank of the output reorder buffer: N complex samples.
//   clk      clock
//   rst      async reset, active-low; clears the array
//   we       capture the parallel frame on wr_re/wr_im
//   wr_re    real parts, slot j at [j*DW +: DW] (bit-reversed order)
//   wr_im    imag parts, same packing
//   rd_idx   natural index to read
//   rd_data  sample at natural index rd_idx (combinational)
module fft_reorder_bank
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [N*DW-1:0]   wr_re,
    input  logic [N*DW-1:0]   wr_im,
    input  logic [LOGN-1:0]   rd_idx,
    output cplx_t             rd_data
);

    cplx_t mem [N];

    // Slot j of the butterfly output is X[bitrev(j)]; storing it there
    // turns the read side into a plain incrementing address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                mem[k] <= '0;
            end
        end else if (we) begin
            for (int j = 0; j < N; j++) begin
                mem[bitrev(LOGN'(j))] <= {wr_re[j*DW +: DW], wr_im[j*DW +: DW]};
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fft8_out_reorder.sv
// Output stage of the 8-point FFT: takes one bit-reversed parallel frame
// per handshake into a ping-pong pair of banks and streams it out one
// sample per cycle in natural order.
//   clk        clock
//   rst        async reset, active-low
//   in_valid   parallel frame present on in_re/in_im
//   in_ready   the bank under the write pointer is empty
//   in_re      real parts, slot j at [j*DW +: DW]
//   in_im      imag parts, same packing
//   out_valid  the bank under the read pointer is full
//   out_ready  downstream takes the sample this cycle
//   out_re     real part of X[out_idx]
//   out_im     imag part of X[out_idx]
//   out_idx    natural index of the current sample
//   out_last   current sample is the last of its frame
module fft8_out_reorder
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DW-1:0]     in_re,
    input  logic [N*DW-1:0]     in_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_re,
    output logic [DW-1:0]       out_im,
    output logic [LOGN-1:0]     out_idx,
    output logic                out_last
);

    localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N-1);

    logic [1:0]      full;
    logic            wr_bank;
    logic            rd_bank;
    logic [LOGN-1:0] rd_cnt;

    logic            wr_en;
    logic            rd_en;
    logic            rd_done;
    cplx_t           rd_data0;
    cplx_t           rd_data1;
    cplx_t           rd_sel;

    // Both handshake outputs depend only on registered flags/pointers,
    // so there is no combinational path from out_ready to in_ready.
    assign in_ready  = ~full[wr_bank];
    assign out_valid = full[rd_bank];

    assign wr_en   = in_valid & in_ready;
    assign rd_en   = out_valid & out_ready;
    assign rd_done = rd_en & (rd_cnt == LAST_IDX);

    // A write only targets an empty bank and a drain only a full one,
    // so the two flag updates never hit the same bit in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
        end else begin
            if (wr_en) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
            end
            if (rd_en) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_done) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end
        end
    end

    fft_reorder_bank u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en & ~wr_bank),
        .wr_re   (in_re),
        .wr_im   (in_im),
        .rd_idx  (rd_cnt),
        .rd_data (rd_data0)
    );

    fft_reorder_bank u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en & wr_bank),
        .wr_re   (in_re),
        .wr_im   (in_im),
        .rd_idx  (rd_cnt),
        .rd_data (rd_data1)
    );

    assign rd_sel   = rd_bank ? rd_data1 : rd_data0;
    assign out_re   = rd_sel.re;
    assign out_im   = rd_sel.im;
    assign out_idx  = rd_cnt;
    assign out_last = out_valid & (rd_cnt == LAST_IDX);

endmodule
